// File: rtl/epoch_access_arbiter.sv
// epoch_access_arbiter: round-robin arbiter with lock and watchdog sharing
// the epoch timer load/snapshot path between two requesters.
module epoch_access_arbiter #(
    parameter int WIDTH    = 64,
    parameter int LOCK_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             one_hz,
    input  logic [WIDTH-1:0] timer_time,
    output logic [WIDTH-1:0] timer_load_data,
    output logic             timer_le,
    input  logic             r0_req,
    input  logic             r0_we,
    input  logic [WIDTH-1:0] r0_wdata,
    input  logic             r0_lock,
    output logic             r0_gnt,
    output logic             r0_done,
    output logic [WIDTH-1:0] r0_rdata,
    input  logic             r1_req,
    input  logic             r1_we,
    input  logic [WIDTH-1:0] r1_wdata,
    input  logic             r1_lock,
    output logic             r1_gnt,
    output logic             r1_done,
    output logic [WIDTH-1:0] r1_rdata,
    output logic             lock_abort
);
    localparam int WD_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [2:0] {IDLE, READ, RDONE, WRITE, WDONE, LOCKED} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_owner;
    logic             r_last;
    logic [WD_W-1:0]  r_wd;
    logic [WIDTH-1:0] r_load;
    logic [WIDTH-1:0] r_rdata0;
    logic [WIDTH-1:0] r_rdata1;
    logic             w_accept;
    logic             w_win;
    logic             w_own_req;
    logic             w_own_lock;
    logic             w_expire;
    logic             w_done;

    assign w_own_req  = r_owner ? r1_req : r0_req;
    assign w_own_lock = r_owner ? r1_lock : r0_lock;
    assign w_expire   = (r_state == LOCKED) && (r_wd == WD_W'(LOCK_MAX));
    assign w_done     = (r_state == RDONE) || (r_state == WDONE);

    always_comb begin
        w_accept = 1'b0;
        w_win    = r_owner;
        w_next   = r_state;
        case (r_state)
            IDLE: begin
                w_accept = r0_req | r1_req;
                w_win    = (r0_req & r1_req) ? ~r_last : r1_req;
            end
            READ:         w_next = RDONE;
            WRITE:        w_next = one_hz ? WRITE : WDONE;
            RDONE, WDONE: w_next = w_own_lock ? LOCKED : IDLE;
            LOCKED: begin
                // expiry beats a same-cycle request, which must be re-presented
                w_accept = ~w_expire & w_own_req;
                w_next   = (w_expire | ~w_own_lock) ? IDLE : LOCKED;
            end
            default:      w_next = IDLE;
        endcase
        if (w_accept)
            w_next = (w_win ? r1_we : r0_we) ? WRITE : READ;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_wd     <= '0;
            r_load   <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_win;
                r_load  <= w_win ? r1_wdata : r0_wdata;
                if (r_state == IDLE)
                    r_last <= w_win;
            end
            if (w_done)
                r_wd <= '0;
            else if (r_state == LOCKED && w_next == LOCKED)
                r_wd <= r_wd + WD_W'(1);
            if (r_state == READ && !r_owner)
                r_rdata0 <= timer_time;
            if (r_state == READ && r_owner)
                r_rdata1 <= timer_time;
        end
    end

    assign r0_gnt          = (r_state != IDLE) && !r_owner;
    assign r1_gnt          = (r_state != IDLE) && r_owner;
    assign r0_done         = w_done && !r_owner;
    assign r1_done         = w_done && r_owner;
    assign r0_rdata        = r_rdata0;
    assign r1_rdata        = r_rdata1;
    assign timer_load_data = r_load;
    assign timer_le        = (r_state == WRITE) && !one_hz;
    assign lock_abort      = w_expire;
endmodule

// File: doc/epoch_access_arbiter.md
Name: epoch_access_arbiter

Overview:
- Shares the 64-bit epoch timer's load and snapshot path between two requesters, e.g. the SPI command FSM (requester 0) and a second host interface (requester 1).
- Requesters issue single read (snapshot) or write (load) transactions using a req/gnt/done handshake.
- An optional lock holds the grant across a read-modify-write sequence. A watchdog bounds how long a lock can be held.
- Loads never coincide with a one_hz tick, so a load is not corrupted by a simultaneous increment.

Parameters:
- WIDTH, 64, timer data width.
- LOCK_MAX, 255, maximum idle cycles a locked grant is held before forced release; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- one_hz  in  1  one-cycle tick from the divider.
- timer_time  in  WIDTH  current timer value.
- timer_load_data  out  WIDTH  value to load into the timer.
- timer_le  out  1  timer load enable, one cycle.
- rN_req  in  1  transaction request (N = 0, 1).
- rN_we  in  1  1 = write/load, 0 = read/snapshot; sampled at acceptance.
- rN_wdata  in  WIDTH  load value; sampled at acceptance.
- rN_lock  in  1  keep the grant after done; sampled in the done cycle.
- rN_gnt  out  1  requester N owns the timer path.
- rN_done  out  1  one-cycle transaction completion.
- rN_rdata  out  WIDTH  snapshot; valid from done, held until N's next read completes.
- lock_abort  out  1  one-cycle pulse when the watchdog forces a lock release.

Behaviour:
- Reset (rst low, async):
  - state IDLE; all gnt, done, timer_le and lock_abort = 0.
  - rdata = 0, timer_load_data = 0, watchdog = 0.
  - Round-robin pointer last = 1, so r0 wins the first tie.
  - A transaction in flight is dropped; no timer_le is issued afterwards.
- States: IDLE, READ, RDONE, WRITE, WDONE, LOCKED.
- IDLE (acceptance):
  - Only r0_req → accept r0. Only r1_req → accept r1. Both → accept the requester != last.
  - On accept: set last = winner, owner = winner, latch we and wdata (wdata → timer_load_data).
  - Next state is READ if we = 0, else WRITE.
- READ:
  - owner gnt = 1.
  - timer_time is registered into owner rdata at the end of this cycle. Reads ignore one_hz.
  - Next state RDONE.
- RDONE:
  - gnt = 1, done = 1, rdata valid.
  - Read latency: req sampled in cycle 0 → done in cycle 2.
- WRITE:
  - gnt = 1.
  - timer_le = ~one_hz (combinational). timer_load_data holds the latched wdata.
  - If one_hz = 1, stay in WRITE (deferred by one cycle per tick). Otherwise go to WDONE.
  - Write latency with no tick: req in cycle 0 → timer_le in cycle 1 → done in cycle 2.
- WDONE: gnt = 1, done = 1.
- Done-cycle exit, from both RDONE and WDONE:
  - owner lock = 1 → LOCKED, watchdog cleared to 0.
  - Otherwise → IDLE, gnt drops next cycle.
  - req in the done cycle is ignored. A requester still asserting req in the cycle after done starts a new transaction; requesters must deassert req in the done cycle.
- LOCKED:
  - owner gnt held = 1; the other requester waits.
  - owner req = 1 → accept with no arbitration. last is unchanged. Go to READ or WRITE.
  - Else owner lock = 0 → IDLE.
  - Else the watchdog increments. When it reaches LOCK_MAX: lock_abort pulses in that cycle, state → IDLE, gnt drops next cycle.
  - A req arriving in the same cycle the watchdog expires is ignored and must be re-presented.
- Invariants:
  - At most one gnt is high at any time.
  - gnt is continuous from the cycle after acceptance through the done cycle (and through LOCKED).
  - timer_le is high only in WRITE with one_hz = 0.
  - Non-owner req/we/wdata are ignored while granted.
  - rdata of the non-owner requester is unaffected.

Test Plan:
- Single read: r0_req, timer_time=64'h1234 → r0_gnt in cycles 1–2, r0_done in cycle 2, r0_rdata=64'h1234, timer_le never high.
- Write deferred by tick: r1_req, we=1, wdata=64'hDEAD_BEEF, one_hz=1 in cycle 1 → timer_le=0 in cycle 1, timer_le=1 with timer_load_data=64'hDEAD_BEEF in cycle 2, r1_done in cycle 3.
- Round robin: r0 and r1 hold req continuously, each dropping req in its done cycle and re-raising it the next cycle → grants alternate r0, r1, r0, r1; never two gnt high.
- Lock RMW: r0 read with lock=1, then r0 write 2 cycles later while r1_req is held → r0_gnt stays high throughout, r1 is accepted only after r0 releases.
- Watchdog: LOCK_MAX=4, r0 locks then stays idle → lock_abort pulses 4 cycles after entering LOCKED, r0_gnt drops, pending r1 is accepted next.
- Reset mid-write: rst low during WRITE with one_hz=1 → all outputs 0 immediately, no timer_le after release, first tie goes to r0.
